// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the microcpu bus responder:
// I/O page offsets, STATUS bit positions and the serial TX states.
package cpu_bus_pkg;

    localparam logic [2:0] IO_GPIO_OUT = 3'd0;
    localparam logic [2:0] IO_GPIO_IN  = 3'd1;
    localparam logic [2:0] IO_TMR_LO   = 3'd2;
    localparam logic [2:0] IO_TMR_HI   = 3'd3;
    localparam logic [2:0] IO_TX_DATA  = 3'd4;
    localparam logic [2:0] IO_STATUS   = 3'd5;

    localparam int ST_BUSY = 0;
    localparam int ST_OVF  = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/bus_uart_tx.sv
// 8N1 serial transmitter, BAUD_DIV clocks per bit, LSB first.
// busy drops during the last stop-bit clock so a new load chains seamlessly.
module bus_uart_tx
    import cpu_bus_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    tx_state_e      state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     sh_q, sh_d;
    logic           tx_q, tx_d;
    logic           tick;

    assign tick = (cnt_q == CW'(BAUD_DIV - 1));
    assign busy = (state_q != TX_IDLE) && !((state_q == TX_STOP) && tick);
    assign tx   = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = 1'b1;
        unique case (state_q)
            TX_IDLE: cnt_d = '0;
            TX_START: begin
                if (tick) begin
                    state_d = TX_DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    sh_d  = {1'b0, sh_q[7:1]};
                    if (bit_q == 3'd7) state_d = TX_STOP;
                    else bit_d = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TX_STOP: begin
                if (tick) begin
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (load && !busy) begin
            state_d = TX_START;
            cnt_d   = '0;
            bit_d   = 3'd0;
            sh_d    = data;
        end
        // Line level is registered from the next state to keep tx glitch-free.
        unique case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = sh_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the microcpu byte bus: byte RAM at 0x0000
// plus an 8-byte I/O page with GPIO, prescaled timer and serial TX.
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int unsigned RAM_AW    = 10,
    parameter logic [15:0] IO_BASE   = 16'hFF00,
    parameter int unsigned TIMER_DIV = 1,
    parameter int unsigned BAUD_DIV  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] address,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic [7:0]  gpio_out,
    input  logic [7:0]  gpio_in,
    output logic        tx
);

    localparam int unsigned RAM_SIZE = 1 << RAM_AW;
    localparam int unsigned PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [7:0]    mem [RAM_SIZE];
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    gpio_q;
    logic [7:0]    sync1_q, sync2_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   tmr_q, tmr_d;
    logic [7:0]    snap_q, snap_d;
    logic          ovf_q, ovf_d;
    logic          ovf_clr;
    logic          busy;
    logic [7:0]    status;

    logic       ram_hit, io_hit, rd_en;
    logic [2:0] off;
    logic       wr_gpio, wr_tmr, wr_tx, tx_load;

    assign ram_hit = (address[15:RAM_AW] == '0);
    assign io_hit  = (address[15:3] == IO_BASE[15:3]);
    assign off     = address[2:0];
    assign rd_en   = read & ~write;

    assign wr_gpio = write & io_hit & (off == IO_GPIO_OUT);
    assign wr_tmr  = write & io_hit & ((off == IO_TMR_LO) | (off == IO_TMR_HI));
    assign wr_tx   = write & io_hit & (off == IO_TX_DATA);
    assign tx_load = wr_tx & ~busy;

    assign rdata    = rdata_q;
    assign gpio_out = gpio_q;

    always_comb begin
        status         = 8'h00;
        status[ST_BUSY] = busy;
        status[ST_OVF]  = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (write && ram_hit) mem[address[RAM_AW-1:0]] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        snap_d  = snap_q;
        ovf_clr = 1'b0;
        if (rd_en) begin
            rdata_d = 8'h00;
            unique case (1'b1)
                ram_hit: rdata_d = mem[address[RAM_AW-1:0]];
                io_hit: begin
                    case (off)
                        IO_GPIO_OUT: rdata_d = gpio_q;
                        IO_GPIO_IN:  rdata_d = sync2_q;
                        IO_TMR_LO: begin
                            rdata_d = tmr_q[7:0];
                            snap_d  = tmr_q[15:8];
                        end
                        IO_TMR_HI:   rdata_d = snap_q;
                        IO_STATUS: begin
                            rdata_d = status;
                            ovf_clr = 1'b1;
                        end
                        default:     rdata_d = 8'h00;
                    endcase
                end
                default: rdata_d = 8'h00;
            endcase
        end
    end

    always_comb begin
        pre_d = pre_q + PW'(1);
        tmr_d = tmr_q;
        if (wr_tmr) begin
            pre_d = '0;
            tmr_d = 16'h0000;
        end else if (pre_q == PW'(TIMER_DIV - 1)) begin
            pre_d = '0;
            tmr_d = tmr_q + 16'd1;
        end
    end

    // A new overflow beats a same-edge STATUS read clear.
    assign ovf_d = (wr_tx & busy) | (ovf_q & ~ovf_clr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 8'h00;
            gpio_q  <= 8'h00;
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            pre_q   <= '0;
            tmr_q   <= 16'h0000;
            snap_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            if (wr_gpio) gpio_q <= wdata;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            tmr_q   <= tmr_d;
            snap_q  <= snap_d;
            ovf_q   <= ovf_d;
        end
    end

    bus_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst),
        .load  (tx_load),
        .data  (wdata),
        .busy  (busy),
        .tx    (tx)
    );

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Scoreboard bench for cpu_bus_responder: reads queue expected bytes,
// a negedge monitor pops and compares them; pins are checked inline.
module tb_cpu_bus_responder;

    localparam logic [15:0] IO = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_in = 8'h00;
    logic        tx;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      nm;
        logic [7:0] exp;
        bit         cap;
    } rsp_t;

    rsp_t       sb_q[$];
    logic [7:0] cap_q[$];
    logic       rd_v;

    always #5 clk = ~clk;

    cpu_bus_responder dut (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .tx       (tx)
    );

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) rd_v <= 1'b0;
        else      rd_v <= read && !write;
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rd_v) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_read", {8'h00, rdata}, 16'hxxxx);
            end else begin
                e = sb_q.pop_front();
                if (e.cap) cap_q.push_back(rdata);
                else chk(e.nm, {8'h00, rdata}, {8'h00, e.exp});
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        address = a;
        wdata   = d;
        write   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic issue_read(input logic [15:0] a, input logic [7:0] e,
                              input bit cap, input string nm);
        rsp_t r;
        r.nm  = nm;
        r.exp = e;
        r.cap = cap;
        sb_q.push_back(r);
        address = a;
        read    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] e,
                           input string nm);
        issue_read(a, e, 1'b0, nm);
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
        chk("drain", 16'(sb_q.size()), 16'd0);
    endtask

    task automatic check_tmr(input string nm, input int lo_lim);
        logic [7:0]  lo, hi;
        logic [15:0] v;
        issue_read(IO + 16'd2, 8'h00, 1'b1, "");
        issue_read(IO + 16'd3, 8'h00, 1'b1, "");
        drain();
        total++;
        if (cap_q.size() < 2) begin
            bad++;
            $display("FAIL %s got=%0d_captures exp=2", nm, cap_q.size());
        end else begin
            lo = cap_q.pop_front();
            hi = cap_q.pop_front();
            v  = {hi, lo};
            if (int'(v) < lo_lim || int'(v) > lo_lim + 2) begin
                bad++;
                $display("FAIL %s got=%0d exp=%0d..%0d", nm, v, lo_lim,
                         lo_lim + 2);
            end
        end
    endtask

    task automatic check_frame(input logic [7:0] d, input string nm);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            repeat ((i == 0) ? 8 : 16) @(negedge clk);
            chk($sformatf("%s_bit%0d", nm, i), {15'd0, tx}, {15'd0, f[i]});
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gpio_in = 8'hC3;
        #17;
        chk("rst_rdata", {8'h00, rdata}, 16'h0000);
        chk("rst_gpio", {8'h00, gpio_out}, 16'h0000);
        chk("rst_tx", {15'd0, tx}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_write(16'h0000, 8'h3C);
        do_write(IO, 8'h11);
        do_read(16'h0000, 8'h3C, "ram0_pre");
        drain();
        #2 rst = 1'b0;
        #1;
        chk("rst2_rdata", {8'h00, rdata}, 16'h0000);
        chk("rst2_gpio", {8'h00, gpio_out}, 16'h0000);
        chk("rst2_tx", {15'd0, tx}, 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_read(16'h0000, 8'h3C, "ram0_kept");
        do_write(16'h0010, 8'h5A);
        do_read(16'h0010, 8'h5A, "ram10");
        do_write(16'h0800, 8'h77);
        do_read(16'h0800, 8'h00, "unmapped");
        do_read(16'h0000, 8'h3C, "no_alias");
        do_write(IO, 8'hA5);
        chk("gpio_out", {8'h00, gpio_out}, 16'h00A5);
        do_read(IO, 8'hA5, "gpio_rb");
        do_read(IO + 16'd1, 8'hC3, "gpio_in");
        do_read(IO + 16'd4, 8'h00, "txdata_rd");
        do_read(IO + 16'd6, 8'h00, "rsvd6");
        do_read(IO + 16'd5, 8'h00, "status_idle");
        drain();

        do_write(IO + 16'd2, 8'hFF);
        repeat (300) @(negedge clk);
        check_tmr("tmr300", 300);
        do_write(IO + 16'd3, 8'h00);
        repeat (65536 + 50) @(negedge clk);
        check_tmr("tmr_wrap", 50);

        do_write(IO + 16'd4, 8'h41);
        fork
            check_frame(8'h41, "f1");
            begin
                do_read(IO + 16'd5, 8'h01, "st_busy");
                do_write(IO + 16'd4, 8'h99);
                do_read(IO + 16'd5, 8'h03, "st_ovf");
                do_read(IO + 16'd5, 8'h01, "st_ovf_clr");
            end
        join
        repeat (10) @(negedge clk);
        chk("tx_idle", {15'd0, tx}, 16'd1);
        do_read(IO + 16'd5, 8'h00, "st_done");
        drain();

        do_write(IO + 16'd4, 8'h41);
        repeat (158) @(negedge clk);
        do_write(IO + 16'd4, 8'h55);
        do_write(IO + 16'd4, 8'h0F);
        fork
            check_frame(8'h0F, "f2");
            begin
                do_read(IO + 16'd5, 8'h03, "b2b_st");
                do_read(IO + 16'd5, 8'h01, "b2b_st2");
            end
        join
        repeat (10) @(negedge clk);
        do_read(IO + 16'd5, 8'h00, "b2b_done");
        drain();

        do_write(IO + 16'd4, 8'h00);
        repeat (40) @(negedge clk);
        chk("pre_rst_tx", {15'd0, tx}, 16'd0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_tx", {15'd0, tx}, 16'd1);
        chk("midrst_gpio", {8'h00, gpio_out}, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_read(IO + 16'd5, 8'h00, "st_after_rst");
        do_read(IO, 8'h00, "gpio_after_rst");
        chk("tx_after_rst", {15'd0, tx}, 16'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
